lenet_stream_conv: RTL and testbench

- Streaming, parametrised successor to the LeNet convolution stage.
- Accepts one single-channel pixel per cycle in raster order over a valid/ready handshake.
- Uses K-1 line buffers and a KxK window to compute CH_OUT parallel valid-mode (no padding) convolutions, with optional ReLU.
- Emits one CH_OUT-wide result per complete window over valid/ready.
- Weights are loaded through a write port while idle, replacing the fully parallel kernel arrays of the previous generation.

---
 rtl/lenet_stream_conv.sv | 192 +++++++++++++++++++
 tb/tb_lenet_stream_conv.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/lenet_stream_conv.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | lenet_stream_conv: streaming KxK valid-mode convolution, CH_OUT channels |
// | Optional: LENET_STREAM_RELU_EN fuses ReLU after saturation. Rev 1.0      |
// +--------------------------------------------------------------------------+
module lenet_stream_conv #(
   parameter int DW     = 16,
   parameter int FRAC   = 8,
   parameter int K      = 5,
   parameter int IMG_W  = 28,
   parameter int IMG_H  = 28,
   parameter int CH_OUT = 2
) (
   input  logic                            clk,
   input  logic                            reset_n,
   input  logic                            start,
   output logic                            busy,
   output logic                            done,
   input  logic                            wt_we,
   input  logic [$clog2(CH_OUT*K*K)-1:0]   wt_addr,
   input  logic [DW-1:0]                   wt_data,
   input  logic                            in_valid,
   output logic                            in_ready,
   input  logic [DW-1:0]                   in_data,
   output logic                            out_valid,
   input  logic                            out_ready,
   output logic [CH_OUT*DW-1:0]            out_data,
   output logic                            out_last
);

   localparam int NW   = CH_OUT * K * K;
   localparam int AW   = $clog2(NW);
   localparam int PW   = 2 * DW;
   localparam int ACCW = PW + $clog2(K * K);
   localparam int SRL  = (K - 1) * IMG_W + K;
   localparam int CW   = $clog2(IMG_W);
   localparam int RW   = $clog2(IMG_H);

   localparam logic [CW-1:0] COL_FIRST = CW'(K - 1);
   localparam logic [CW-1:0] COL_LAST  = CW'(IMG_W - 1);
   localparam logic [RW-1:0] ROW_FIRST = RW'(K - 1);
   localparam logic [RW-1:0] ROW_LAST  = RW'(IMG_H - 1);
   localparam logic [AW:0]   NW_W      = (AW + 1)'(NW);

   localparam logic signed [ACCW-1:0] SAT_MAX = {{(ACCW-DW+1){1'b0}}, {(DW-1){1'b1}}};
   localparam logic signed [ACCW-1:0] SAT_MIN = {{(ACCW-DW+1){1'b1}}, {(DW-1){1'b0}}};

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_RUN   = 2'd1,
      S_DRAIN = 2'd2
   } state_t;

   state_t                   state_q, state_d;
   logic [CW-1:0]            col_q, col_d;
   logic [RW-1:0]            row_q, row_d;
   logic                     done_q, done_d;
   logic                     out_valid_q, out_valid_d;
   logic                     out_last_q, out_last_d;
   logic [CH_OUT*DW-1:0]     out_data_q, out_data_d;
   logic signed [DW-1:0]     wt_q [NW];
   logic signed [DW-1:0]     wt_d [NW];
   logic signed [DW-1:0]     sr_q [SRL];
   logic signed [DW-1:0]     sr_d [SRL];
   logic signed [DW-1:0]     nx   [SRL];

   logic                     accept;
   logic                     win_done;
   logic                     pix_last;
   logic signed [PW-1:0]     prod;
   logic signed [ACCW-1:0]   acc [CH_OUT];
   logic signed [ACCW-1:0]   shr [CH_OUT];
   logic [CH_OUT*DW-1:0]     res;

   assign busy      = (state_q != S_IDLE);
   assign done      = done_q;
   assign out_valid = out_valid_q;
   assign out_data  = out_data_q;
   assign out_last  = out_last_q;
   assign in_ready  = (state_q == S_RUN) && (!out_valid_q || out_ready);
   assign accept    = in_valid && in_ready;
   assign pix_last  = (row_q == ROW_LAST) && (col_q == COL_LAST);
   assign win_done  = accept && (row_q >= ROW_FIRST) && (col_q >= COL_FIRST);

   // One long shift register serves as K-1 line buffers plus the window;
   // tap (dr, dc) back from the newest pixel sits at dr*IMG_W + dc.
   always_comb begin
      nx[0] = in_data;
      for (int i = 1; i < SRL; i++) nx[i] = sr_q[i-1];
      for (int i = 0; i < SRL; i++) sr_d[i] = accept ? nx[i] : sr_q[i];
   end

   always_comb begin
      res  = '0;
      prod = '0;
      for (int ch = 0; ch < CH_OUT; ch++) begin
         acc[ch] = '0;
         for (int r = 0; r < K; r++) begin
            for (int c = 0; c < K; c++) begin
               prod = PW'(wt_q[ch*K*K + r*K + c]) * PW'(nx[(K-1-r)*IMG_W + (K-1-c)]);
               acc[ch] = acc[ch] + {{(ACCW-PW){prod[PW-1]}}, prod};
            end
         end
         shr[ch] = acc[ch] >>> FRAC;
         if (shr[ch] > SAT_MAX)      res[ch*DW +: DW] = SAT_MAX[DW-1:0];
         else if (shr[ch] < SAT_MIN) res[ch*DW +: DW] = SAT_MIN[DW-1:0];
         else                        res[ch*DW +: DW] = shr[ch][DW-1:0];
`ifdef LENET_STREAM_RELU_EN
         if (res[ch*DW + DW - 1]) res[ch*DW +: DW] = '0;
`else
`endif
      end
   end

   always_comb begin
      state_d     = state_q;
      col_d       = col_q;
      row_d       = row_q;
      done_d      = 1'b0;
      out_valid_d = out_valid_q;
      out_data_d  = out_data_q;
      out_last_d  = out_last_q;
      for (int i = 0; i < NW; i++) wt_d[i] = wt_q[i];

      case (state_q)
         S_IDLE: begin
            if (start) begin
               state_d = S_RUN;
               col_d   = '0;
               row_d   = '0;
            end
            if (wt_we && ({1'b0, wt_addr} < NW_W)) wt_d[wt_addr] = wt_data;
         end
         S_RUN: begin
            if (accept && pix_last) state_d = S_DRAIN;
         end
         S_DRAIN: begin
            if (out_valid_q && out_ready && out_last_q) begin
               state_d = S_IDLE;
               done_d  = 1'b1;
            end
         end
         default: state_d = S_IDLE;
      endcase

      if (accept) begin
         if (col_q == COL_LAST) begin
            col_d = '0;
            row_d = (row_q == ROW_LAST) ? '0 : row_q + 1'b1;
         end else begin
            col_d = col_q + 1'b1;
         end
      end

      // A load on the same edge as a consume wins, keeping out_valid high.
      if (out_valid_q && out_ready) begin
         out_valid_d = 1'b0;
         out_last_d  = 1'b0;
      end
      if (win_done) begin
         out_valid_d = 1'b1;
         out_data_d  = res;
         out_last_d  = pix_last;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q     <= S_IDLE;
         col_q       <= '0;
         row_q       <= '0;
         done_q      <= 1'b0;
         out_valid_q <= 1'b0;
         out_data_q  <= '0;
         out_last_q  <= 1'b0;
         for (int i = 0; i < NW; i++)  wt_q[i] <= '0;
         for (int i = 0; i < SRL; i++) sr_q[i] <= '0;
      end else begin
         state_q     <= state_d;
         col_q       <= col_d;
         row_q       <= row_d;
         done_q      <= done_d;
         out_valid_q <= out_valid_d;
         out_data_q  <= out_data_d;
         out_last_q  <= out_last_d;
         for (int i = 0; i < NW; i++)  wt_q[i] <= wt_d[i];
         for (int i = 0; i < SRL; i++) sr_q[i] <= sr_d[i];
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_lenet_stream_conv.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_lenet_stream_conv: scoreboard bench, 6x6 image, K=3, CH_OUT=2, FRAC=0  |
// | Rev 1.0                                                                    |
// +--------------------------------------------------------------------------+
module tb_lenet_stream_conv;

   localparam int DW     = 16;
   localparam int FRAC   = 0;
   localparam int K      = 3;
   localparam int IMG_W  = 6;
   localparam int IMG_H  = 6;
   localparam int CH_OUT = 2;
   localparam int NW     = CH_OUT * K * K;
   localparam int AW     = $clog2(NW);
   localparam int NPIX   = IMG_W * IMG_H;

   logic                    clk = 1'b0;
   logic                    reset_n = 1'b0;
   logic                    start = 1'b0;
   logic                    busy, done;
   logic                    wt_we = 1'b0;
   logic [AW-1:0]           wt_addr = '0;
   logic [DW-1:0]           wt_data = '0;
   logic                    in_valid = 1'b0;
   logic                    in_ready;
   logic [DW-1:0]           in_data = '0;
   logic                    out_valid;
   logic                    out_ready = 1'b1;
   logic [CH_OUT*DW-1:0]    out_data;
   logic                    out_last;

   typedef struct {
      logic [CH_OUT*DW-1:0] data;
      bit                   last;
   } exp_t;

   exp_t                    sb_q [$];
   logic signed [DW-1:0]    img  [NPIX];
   logic signed [DW-1:0]    wts  [NW];
   int                      n_checks = 0;
   int                      n_errors = 0;
   bit                      frame_done = 1'b0;

   lenet_stream_conv #(
      .DW(DW), .FRAC(FRAC), .K(K), .IMG_W(IMG_W), .IMG_H(IMG_H), .CH_OUT(CH_OUT)
   ) dut (
      .clk(clk), .reset_n(reset_n), .start(start), .busy(busy), .done(done),
      .wt_we(wt_we), .wt_addr(wt_addr), .wt_data(wt_data),
      .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
      .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
      .out_last(out_last)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, act, exp);
      end
   endtask

   function automatic logic [CH_OUT*DW-1:0] model(input int r, input int c);
      logic [CH_OUT*DW-1:0] v;
      longint               acc;
      v = '0;
      for (int ch = 0; ch < CH_OUT; ch++) begin
         acc = 0;
         for (int kr = 0; kr < K; kr++)
            for (int kc = 0; kc < K; kc++)
               acc += longint'(wts[ch*K*K + kr*K + kc]) *
                      longint'(img[(r-K+1+kr)*IMG_W + (c-K+1+kc)]);
         acc = acc >>> FRAC;
         if (acc > 32767)  acc = 32767;
         if (acc < -32768) acc = -32768;
`ifdef LENET_STREAM_RELU_EN
         if (acc < 0) acc = 0;
`endif
         v[ch*DW +: DW] = acc[DW-1:0];
      end
      return v;
   endfunction

   task automatic load_w(input int mode);
      for (int i = 0; i < NW; i++) begin
         if (mode == 0) wts[i] = (i < K*K) ? 16'sd1 : ((i == K*K + 4) ? 16'sd2 : 16'sd0);
         else           wts[i] = 16'sh7FFF;
         @(negedge clk);
         wt_we = 1'b1; wt_addr = AW'(i); wt_data = wts[i];
      end
      @(negedge clk);
      wt_we = 1'b0;
   endtask

   task automatic send_px(input int idx, input bit inj);
      int   n;
      exp_t e;
      n = 0;
      @(negedge clk);
      in_valid = 1'b1; in_data = img[idx];
      start = inj; wt_we = inj; wt_addr = '0; wt_data = 16'h0100;
      #1;
      while (!in_ready && n < 200) begin
         @(negedge clk); #1; n++;
      end
      if (!in_ready) check("in_ready_timeout", 64'd0, 64'd1);
      if ((idx / IMG_W) >= K-1 && (idx % IMG_W) >= K-1) begin
         e.data = model(idx / IMG_W, idx % IMG_W);
         e.last = (idx == NPIX-1);
         sb_q.push_back(e);
      end
      @(posedge clk);
   endtask

   task automatic run_frame(input int npx, input bit inj);
      int n;
      frame_done = 1'b0;
      @(negedge clk); start = 1'b1;
      @(negedge clk); start = 1'b0;
      #1 check("busy_after_start", 64'(busy), 64'd1);
      for (int i = 0; i < npx; i++) send_px(i, inj && (i == 10));
      @(negedge clk);
      in_valid = 1'b0; start = 1'b0; wt_we = 1'b0;
      if (npx == NPIX) begin
         n = 0;
         while (!frame_done && n < 2000) begin @(negedge clk); n++; end
         if (!frame_done) check("frame_timeout", 64'd0, 64'd1);
      end
   endtask

   task automatic stall_first();
      int n;
      n = 0;
      @(negedge clk); #1;
      while (!out_valid && n < 200) begin @(negedge clk); #1; n++; end
      for (int i = 0; i < 5; i++) begin
         check("stall_in_ready", 64'(in_ready), 64'd0);
         check("stall_hold", 64'(out_data), 64'h000E_003F);
         @(negedge clk); #1;
      end
      @(negedge clk);
      out_ready = 1'b1;
   endtask

   // Scoreboard consumer: a handshake sampled here completes on the next rising edge.
   initial begin
      exp_t e;
      forever begin
         @(negedge clk); #1;
         if (reset_n && out_valid && out_ready) begin
            if (sb_q.size() == 0) begin
               check("unexpected_out", 64'(out_data), 64'd0);
            end else begin
               e = sb_q.pop_front();
               check("out_data", 64'(out_data), 64'(e.data));
               check("out_last", 64'(out_last), 64'(e.last));
               if (e.last) begin
                  @(posedge clk); #1;
                  check("done_pulse", 64'(done), 64'd1);
                  check("busy_end", 64'(busy), 64'd0);
                  @(posedge clk); #1;
                  check("done_single", 64'(done), 64'd0);
                  frame_done = 1'b1;
               end
            end
         end
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL global_timeout: got running expected finished");
      $fatal(1, "timeout");
   end

   initial begin
      repeat (3) @(negedge clk);
      #1;
      check("rst_busy", 64'(busy), 64'd0);
      check("rst_done", 64'(done), 64'd0);
      check("rst_in_ready", 64'(in_ready), 64'd0);
      check("rst_out_valid", 64'(out_valid), 64'd0);
      check("rst_out_data", 64'(out_data), 64'd0);
      check("rst_out_last", 64'(out_last), 64'd0);
      @(negedge clk); reset_n = 1'b1;

      // basic frame: ch0 box filter, ch1 doubled centre
      load_w(0);
      for (int i = 0; i < NPIX; i++) img[i] = DW'(i);
      run_frame(NPIX, 1'b0);

      // backpressure on the first result
      out_ready = 1'b0;
      fork
         run_frame(NPIX, 1'b0);
         stall_first();
      join

      // saturation both directions
      load_w(1);
      for (int i = 0; i < NPIX; i++) img[i] = 16'sh7FFF;
      run_frame(NPIX, 1'b0);
      for (int i = 0; i < NPIX; i++) img[i] = 16'sh8001;
      run_frame(NPIX, 1'b0);

      // mid-frame reset clears weights; start/wt_we during RUN are ignored
      load_w(0);
      for (int i = 0; i < NPIX; i++) img[i] = DW'(i);
      run_frame(20, 1'b0);
      @(negedge clk); reset_n = 1'b0;
      #1;
      check("mid_rst_busy", 64'(busy), 64'd0);
      check("mid_rst_out_valid", 64'(out_valid), 64'd0);
      check("mid_rst_in_ready", 64'(in_ready), 64'd0);
      sb_q.delete();
      @(negedge clk); reset_n = 1'b1;
      for (int i = 0; i < NW; i++) wts[i] = '0;
      run_frame(NPIX, 1'b1);

      check("sb_empty", 64'(sb_q.size()), 64'd0);
      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
`default_nettype wire
